// File: rtl/random_request_arbiter.sv
// Round-robin arbiter sharing one free-running random source; rejects samples >= LIMIT and retries.
// Optional feature macro: RANDOM_NO_REPEAT_EN (also rejects a repeat of the last delivered value).
module random_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int RANGE   = 8,
    parameter int LIMIT   = 10
) (
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    input  logic [RANGE-1:0]   i_Random_Num,
    input  logic [NUM_REQ-1:0] i_Req,
    output logic [NUM_REQ-1:0] o_Grant,
    output logic               o_Valid,
    output logic [RANGE-1:0]   o_Random_Num,
    output logic               o_Busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // LIMIT may equal 2^RANGE, so the compare needs one extra bit.
    localparam logic [RANGE:0] LIMIT_EXT = (RANGE+1)'(LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [PTR_W-1:0]     ptr_r, ptr_nxt_s;
    logic [NUM_REQ-1:0]   grant_r, grant_nxt_s;
    logic                 valid_r, valid_nxt_s;
    logic [RANGE-1:0]     num_r, num_nxt_s;
    logic                 busy_r, busy_nxt_s;

    logic [2*NUM_REQ-1:0] req_dbl_s;
    logic [NUM_REQ-1:0]   req_rot_s;
    logic [PTR_W-1:0]     winner_s;
    logic                 granted_req_s;
    logic                 in_limit_s;
    logic                 accept_s;

`ifdef RANDOM_NO_REPEAT_EN
    logic [RANGE-1:0]     last_r, last_nxt_s;
`endif

    // Rotate requests so bit 0 is the pointer position, then pick the lowest set bit.
    always_comb begin
        req_dbl_s = {i_Req, i_Req} >> ptr_r;
        req_rot_s = req_dbl_s[NUM_REQ-1:0];
        winner_s  = ptr_r;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot_s[i]) begin
                winner_s = PTR_W'((int'(ptr_r) + i) % NUM_REQ);
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Sample acceptance: granted requester still asking and value inside the window.
    always_comb begin
        granted_req_s = |(i_Req & grant_r);
        in_limit_s    = ({1'b0, i_Random_Num} < LIMIT_EXT);
`ifdef RANDOM_NO_REPEAT_EN
        accept_s      = in_limit_s && (i_Random_Num != last_r);
`else
        accept_s      = in_limit_s;
`endif
    end

    // Next-state and next-output logic; all outputs leave through registers.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        grant_nxt_s = grant_r;
        valid_nxt_s = 1'b0;
        num_nxt_s   = num_r;
`ifdef RANDOM_NO_REPEAT_EN
        last_nxt_s  = last_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (|i_Req) begin
                    state_nxt_s = ST_SAMPLE;
                    grant_nxt_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
                    ptr_nxt_s   = PTR_W'((int'(winner_s) + 1) % NUM_REQ);
                end else begin
                    grant_nxt_s = '0;
                end
            end
            ST_SAMPLE: begin
                if (!granted_req_s) begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = '0;
                end else if (accept_s) begin
                    state_nxt_s = ST_DELIVER;
                    num_nxt_s   = i_Random_Num;
                    valid_nxt_s = 1'b1;
`ifdef RANDOM_NO_REPEAT_EN
                    last_nxt_s  = i_Random_Num;
`endif
                end else begin
                    state_nxt_s = ST_SAMPLE;
                end
            end
            ST_DELIVER: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = '0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = '0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            grant_r <= '0;
            valid_r <= 1'b0;
            num_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            grant_r <= grant_nxt_s;
            valid_r <= valid_nxt_s;
            num_r   <= num_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

`ifdef RANDOM_NO_REPEAT_EN
    // Last delivered value, shared by all requesters.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            last_r <= '0;
        end else begin
            last_r <= last_nxt_s;
        end
    end
`endif

    assign o_Grant      = grant_r;
    assign o_Valid      = valid_r;
    assign o_Random_Num = num_r;
    assign o_Busy       = busy_r;

endmodule

// File: tb/tb_random_request_arbiter.sv
// Directed table-driven bench for random_request_arbiter (NUM_REQ=4, RANGE=8, LIMIT=10).
module tb_random_request_arbiter;

    logic       i_Clk;
    logic       i_Reset_n;
    logic [7:0] i_Random_Num;
    logic [3:0] i_Req;
    logic [3:0] o_Grant;
    logic       o_Valid;
    logic [7:0] o_Random_Num;
    logic       o_Busy;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] req;
        logic [7:0] rnd;
        logic [3:0] grant;
        logic       valid;
        logic [7:0] num;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    random_request_arbiter #(.NUM_REQ(4), .RANGE(8), .LIMIT(10)) dut (
        .i_Clk        (i_Clk),
        .i_Reset_n    (i_Reset_n),
        .i_Random_Num (i_Random_Num),
        .i_Req        (i_Req),
        .o_Grant      (o_Grant),
        .o_Valid      (o_Valid),
        .o_Random_Num (o_Random_Num),
        .o_Busy       (o_Busy)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic v,
                           input logic [7:0] n, input logic b);
        chk({tag, "_grant"}, 32'(o_Grant), 32'(g));
        chk({tag, "_valid"}, 32'(o_Valid), 32'(v));
        chk({tag, "_num"},   32'(o_Random_Num), 32'(n));
        chk({tag, "_busy"},  32'(o_Busy), 32'(b));
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic add(input logic [3:0] r, input logic [7:0] s, input logic [3:0] g,
                       input logic v, input logic [7:0] n, input logic b);
        vec_t t;
        t.req = r; t.rnd = s; t.grant = g; t.valid = v; t.num = n; t.busy = b;
        vecs.push_back(t);
    endtask

    task automatic do_reset();
        i_Reset_n = 1'b0;
        @(negedge i_Clk);
        @(negedge i_Clk);
        i_Reset_n = 1'b1;
    endtask

    initial begin
        int rej;
        bit got;
        checks       = 0;
        failures     = 0;
        i_Reset_n    = 1'b0;
        i_Req        = 4'b0000;
        i_Random_Num = 8'd0;

        #12;
        chk_out("reset", 4'b0000, 1'b0, 8'd0, 1'b0);
        @(negedge i_Clk);
        i_Reset_n = 1'b1;

        // Round robin with all four requesting: one delivery every 3 cycles.
        add(4'b1111, 8'd1, 4'b0001, 1'b0, 8'd0, 1'b1);
        add(4'b1111, 8'd1, 4'b0001, 1'b1, 8'd1, 1'b1);
        add(4'b1111, 8'd1, 4'b0000, 1'b0, 8'd1, 1'b0);
        add(4'b1111, 8'd2, 4'b0010, 1'b0, 8'd1, 1'b1);
        add(4'b1111, 8'd2, 4'b0010, 1'b1, 8'd2, 1'b1);
        add(4'b1111, 8'd2, 4'b0000, 1'b0, 8'd2, 1'b0);
        add(4'b1111, 8'd3, 4'b0100, 1'b0, 8'd2, 1'b1);
        add(4'b1111, 8'd3, 4'b0100, 1'b1, 8'd3, 1'b1);
        add(4'b1111, 8'd3, 4'b0000, 1'b0, 8'd3, 1'b0);
        add(4'b1111, 8'd4, 4'b1000, 1'b0, 8'd3, 1'b1);
        add(4'b1111, 8'd4, 4'b1000, 1'b1, 8'd4, 1'b1);
        add(4'b1111, 8'd4, 4'b0000, 1'b0, 8'd4, 1'b0);
        add(4'b1111, 8'd6, 4'b0001, 1'b0, 8'd4, 1'b1);
        add(4'b1111, 8'd6, 4'b0001, 1'b1, 8'd6, 1'b1);
        add(4'b1111, 8'd6, 4'b0000, 1'b0, 8'd6, 1'b0);
        // Single requester 0 with the pointer at 1: scan wraps back to 0.
        add(4'b0001, 8'd3, 4'b0001, 1'b0, 8'd6, 1'b1);
        add(4'b0001, 8'd3, 4'b0001, 1'b1, 8'd3, 1'b1);
        add(4'b0000, 8'd3, 4'b0000, 1'b0, 8'd3, 1'b0);
        // Requester 2 drops during retry; next winner is 3, not 0.
        add(4'b0100, 8'd200, 4'b0100, 1'b0, 8'd3, 1'b1);
        add(4'b0100, 8'd201, 4'b0100, 1'b0, 8'd3, 1'b1);
        add(4'b0000, 8'd5,   4'b0000, 1'b0, 8'd3, 1'b0);
        add(4'b1111, 8'd5,   4'b1000, 1'b0, 8'd3, 1'b1);
        add(4'b1111, 8'd5,   4'b1000, 1'b1, 8'd5, 1'b1);
        add(4'b0000, 8'd5,   4'b0000, 1'b0, 8'd5, 1'b0);
        // LIMIT boundary: 10 rejected, 9 accepted.
        add(4'b0010, 8'd10, 4'b0010, 1'b0, 8'd5, 1'b1);
        add(4'b0010, 8'd10, 4'b0010, 1'b0, 8'd5, 1'b1);
        add(4'b0010, 8'd9,  4'b0010, 1'b1, 8'd9, 1'b1);
        add(4'b0000, 8'd9,  4'b0000, 1'b0, 8'd9, 1'b0);

        foreach (vecs[i]) begin
            i_Req        = vecs[i].req;
            i_Random_Num = vecs[i].rnd;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].valid, vecs[i].num, vecs[i].busy);
        end

        // Dwell: incrementing source starting at 12 must wrap before acceptance.
        i_Req = 4'b0000;
        do_reset();
        i_Req        = 4'b0001;
        i_Random_Num = 8'd12;
        step();
        chk("dwell_grant", 32'(o_Grant), 32'd1);
        rej = 0;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            i_Random_Num = 8'((12 + k) % 256);
            step();
            if (o_Valid) begin
                got = 1'b1;
                break;
            end
            rej++;
        end
        chk("dwell_done", 32'(got), 32'd1);
`ifdef RANDOM_NO_REPEAT_EN
        chk("dwell_cycles", 32'(rej), 32'd245);
        chk("dwell_value", 32'(o_Random_Num), 32'd1);
`else
        chk("dwell_cycles", 32'(rej), 32'd244);
        chk("dwell_value", 32'(o_Random_Num), 32'd0);
`endif
        chk("dwell_busy", 32'(o_Busy), 32'd1);
        i_Req = 4'b0000;
        step();
        chk_out("dwell_end", 4'b0000, 1'b0, o_Random_Num, 1'b0);

        // Asynchronous reset while requester 2 is in SAMPLE.
        do_reset();
        i_Req        = 4'b0100;
        i_Random_Num = 8'd200;
        step();
        chk("prerst_grant", 32'(o_Grant), 32'd4);
        i_Random_Num = 8'd201;
        step();
        #2;
        i_Reset_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 1'b0, 8'd0, 1'b0);
        @(negedge i_Clk);
        i_Reset_n    = 1'b1;
        i_Req        = 4'b1111;
        i_Random_Num = 8'd7;
        step();
        chk("postrst_grant", 32'(o_Grant), 32'd1);

        // Constant source 5 with back-to-back requests from requester 0.
        i_Req = 4'b0000;
        do_reset();
        i_Req        = 4'b0001;
        i_Random_Num = 8'd5;
        step();
        chk_out("rep_e0", 4'b0001, 1'b0, 8'd0, 1'b1);
        step();
        chk_out("rep_e1", 4'b0001, 1'b1, 8'd5, 1'b1);
        step();
        chk_out("rep_e2", 4'b0000, 1'b0, 8'd5, 1'b0);
        step();
        chk_out("rep_e3", 4'b0001, 1'b0, 8'd5, 1'b1);
`ifdef RANDOM_NO_REPEAT_EN
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("rep_hold%0d", k), 4'b0001, 1'b0, 8'd5, 1'b1);
        end
        i_Random_Num = 8'd6;
        step();
        chk_out("rep_new", 4'b0001, 1'b1, 8'd6, 1'b1);
`else
        step();
        chk_out("rep_again", 4'b0001, 1'b1, 8'd5, 1'b1);
`endif
        i_Req = 4'b0000;
        step();
        chk_out("rep_end", 4'b0000, 1'b0, o_Random_Num, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/random_request_arbiter.md
# random_request_arbiter

Shares one free-running random-number source (`RANGE`-bit wrap-around counter) between up to `NUM_REQ` alarm-clock consumers, e.g. the snooze-puzzle digit generator and the alarm-tone selector. Arbitrates requests round-robin and samples the source on behalf of the winner. Rejects samples outside `[0, LIMIT)` and retries on the next cycle. Returns the accepted value with a one-cycle valid pulse.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `RANGE`, 8: width of the random source and of delivered values.
- `LIMIT`, 10: accept a sample only if it is below `LIMIT`; legal range 1..2^`RANGE`.

- `i_Clk`  in  1  system clock.
- `i_Reset_n`  in  1  asynchronous, active-low reset.
- `i_Random_Num`  in  `RANGE`  live output of the random counter source.
- `i_Req`  in  `NUM_REQ`  per-requester request level.
- `o_Grant`  out  `NUM_REQ`  one-hot current owner; all zero when idle.
- `o_Valid`  out  1  one-cycle pulse; `o_Random_Num` is valid for the granted requester.
- `o_Random_Num`  out  `RANGE`  last accepted value; held until the next delivery.
- `o_Busy`  out  1  high in SAMPLE and DELIVER.

## Operation
- **Reset values:**
  - state IDLE
  - `o_Grant`=0, `o_Valid`=0, `o_Random_Num`=0, `o_Busy`=0
  - round-robin pointer=0 (index 0 has highest priority first)
  - last-delivered register=0
- **FSM:**
  - IDLE → SAMPLE when any `i_Req` is set.
    - The winner is the first set bit scanning upward from the pointer, with wrap.
    - Register `o_Grant` one-hot for the winner; pointer ← winner+1 mod `NUM_REQ`.
  - SAMPLE:
    - If the granted `i_Req` bit is low: abort to IDLE, clear `o_Grant`, no `o_Valid`. The pointer keeps its advanced value.
    - Else if `i_Random_Num` < `LIMIT`: latch `o_Random_Num` ← `i_Random_Num`, set `o_Valid`, go to DELIVER.
    - Else stay in SAMPLE and re-test next cycle.
  - DELIVER: `o_Valid`=1 for exactly this cycle, `o_Grant` held, then go to IDLE with `o_Grant` cleared.
- **Comparison width:** `RANGE`+1 bits, zero-extended.
  - `LIMIT`=2^`RANGE` accepts every sample.
  - `LIMIT`=1 accepts only 0.
- **Requester protocol:**
  - Hold the request until the cycle `o_Valid` is high with its own grant bit.
  - Deassert in the following cycle.
  - A request still high after DELIVER is treated as a new request.
- Non-granted requests may change freely; they are ignored until IDLE.
- Simultaneous requests: exactly one is granted per transaction. Each requester is served within `NUM_REQ` transactions.
- Worst-case SAMPLE dwell is 2^`RANGE` − `LIMIT` cycles, given an incrementing source. No timeout.
- Reset asserted mid-transaction: all outputs return to reset values immediately, with no `o_Valid` pulse.

## Timing
- Edge E0 (IDLE, request seen): `o_Grant` and `o_Busy` valid after E0.
- Edge E1 (SAMPLE, sample accepted): `o_Valid` high from E1 to E2; `o_Random_Num` updates at E1.
- Edge E2: back in IDLE, grant cleared. Next grant is possible at E3.
- Best-case latency is 2 cycles from the first request edge to `o_Valid`. Peak throughput is one value per 3 cycles.
- Each rejected sample adds 1 cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `RANDOM_NO_REPEAT_EN`:
  - **Defined:** SAMPLE also rejects a value equal to the last-delivered register. That register updates on every delivery, regardless of requester, and resets to 0, so a first sample of 0 is rejected.
  - **Undefined:** only the `LIMIT` check applies, and the last-delivered register is not instantiated.
  - `LIMIT`=1 with the macro defined is illegal, since it would reject every sample forever.

## Test plan
- Reset, then single request `i_Req`=4'b0001 with the source at 3, `LIMIT`=10:
  - E0: `o_Grant`=0001.
  - E1: `o_Valid`=1, `o_Random_Num`=3.
  - E2: `o_Grant`=0.
- Source at 12, `LIMIT`=10, source wraps at 2^8:
  - SAMPLE dwells 244 cycles (12..255).
  - Delivers 0 when the source wraps, or 1 with the macro defined; delivers on the first accepted value.
- `i_Req`=4'b1111 held continuously:
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Exactly one `o_Valid` per grant, 3 cycles apart.
- Granted requester drops `i_Req` during a SAMPLE retry:
  - Returns to IDLE, no `o_Valid`, `o_Random_Num` unchanged.
  - The next request winner is the index after the aborted one.
- `i_Reset_n` pulsed low while in SAMPLE with `o_Grant`=0100:
  - All outputs 0 asynchronously.
  - Pointer 0, so a 4'b1111 request next grants 0001.
- With `RANDOM_NO_REPEAT_EN`, source held constant at 5, two back-to-back requests:
  - The first delivers 5.
  - The second stays in SAMPLE until the source changes, then delivers the new value.
